dsm_cic_decimator: RTL and testbench

// Receive end of the 4-bit multi-level sigma-delta code stream produced by the modulator quantizer.
// A 3rd-order CIC decimator (M=1) turns the 4-bit code into PCM. This allows on-chip monitoring and

---
 rtl/dsm_pkg.sv | 11 +
 rtl/dsm_cic_comb.sv | 27 ++
 rtl/dsm_cic_decimator.sv | 85 ++++++++
 tb/tb_dsm_cic_decimator.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/dsm_pkg.sv
// dsm_pkg: shared sigma-delta constants, code type and CIC accumulator width helper
package dsm_pkg;
  localparam int CIC_ORDER  = 3;
  localparam int R_LOG2_DEF = 6;
  localparam int IN_W_DEF   = 4;
  localparam int OUT_W_DEF  = 16;
  typedef logic signed [3:0] dsm_code_t;
  function automatic int acc_w(input int in_w, input int r_log2);
    return in_w + CIC_ORDER * r_log2;
  endfunction
endpackage

// File: rtl/dsm_cic_comb.sv
// dsm_cic_comb: one registered CIC comb stage, y <= x - x_dly on adv (modulo 2^W)
// Ports: clk, rst_n (async low), clr (sync clear), adv (advance strobe), x (stage input), y (registered difference)
module dsm_cic_comb
  import dsm_pkg::*;
#(
  parameter int W = acc_w(IN_W_DEF, R_LOG2_DEF)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         adv,
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);
  logic [W-1:0] x_dly;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      x_dly <= '0;
      y     <= '0;
    end else if (clr) begin
      x_dly <= '0;
      y     <= '0;
    end else if (adv) begin
      y     <= x - x_dly;
      x_dly <= x;
    end
endmodule

// File: rtl/dsm_cic_decimator.sv
// dsm_cic_decimator: 3rd-order CIC decimator (R=2^R_LOG2) for the 4-bit sigma-delta code, valid/ready PCM out
// Ports: clk, rst_n (async low), fs_enb (sample strobe), code_in (signed code), clr (sync filter clear),
//        pcm_data/pcm_valid/pcm_ready (output handshake), overrun (sticky lost-sample flag), overrun_clr
module dsm_cic_decimator
  import dsm_pkg::*;
#(
  parameter int R_LOG2 = R_LOG2_DEF,
  parameter int IN_W   = IN_W_DEF,
  parameter int OUT_W  = OUT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fs_enb,
  input  logic [IN_W-1:0]  code_in,
  input  logic             clr,
  output logic [OUT_W-1:0] pcm_data,
  output logic             pcm_valid,
  input  logic             pcm_ready,
  output logic             overrun,
  input  logic             overrun_clr
);
  localparam int ACC_W = acc_w(IN_W, R_LOG2);
  logic [ACC_W-1:0]  i1, i2, i3, i1_n, i2_n, i3_n;
  logic [R_LOG2-1:0] dec_cnt;
  logic [3:0]        pv;
  logic [ACC_W-1:0]  c [4];
  logic [OUT_W-1:0]  pcm_next;
  logic              tick, res;
  assign i1_n = i1 + {{(ACC_W-IN_W){code_in[IN_W-1]}}, code_in};
  assign i2_n = i2 + i1_n;
  assign i3_n = i3 + i2_n;
  // R is a power of two, so R-1 is the all-ones count
  assign tick = fs_enb & ~clr & (dec_cnt == '1);
  assign res  = pv[3] & ~clr;
  assign c[0] = i3;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      i1      <= '0;
      i2      <= '0;
      i3      <= '0;
      dec_cnt <= '0;
      pv      <= '0;
    end else if (clr) begin
      i1      <= '0;
      i2      <= '0;
      i3      <= '0;
      dec_cnt <= '0;
      pv      <= '0;
    end else begin
      if (fs_enb) begin
        i1      <= i1_n;
        i2      <= i2_n;
        i3      <= i3_n;
        dec_cnt <= dec_cnt + 1'b1;
      end
      // pv[k] marks the cycle in which comb stage k+1 (or the output for k=3) consumes the tick's value
      pv <= {pv[2:0], tick};
    end
  for (genvar g = 0; g < CIC_ORDER; g++) begin : g_comb
    dsm_cic_comb #(.W(ACC_W)) u_comb (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (clr),
      .adv  (pv[g]),
      .x    (c[g]),
      .y    (c[g+1])
    );
  end
  // Keep the top OUT_W bits; at small R the accumulator is narrower, so scale up instead
  if (ACC_W >= OUT_W) begin : g_trunc
    assign pcm_next = c[3][ACC_W-1 -: OUT_W];
  end else begin : g_ext
    assign pcm_next = {c[3], {(OUT_W-ACC_W){1'b0}}};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pcm_data  <= '0;
      pcm_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      pcm_data  <= clr ? '0 : res ? pcm_next : pcm_data;
      pcm_valid <= ~clr & (res | (pcm_valid & ~pcm_ready));
      overrun   <= (res & pcm_valid & ~pcm_ready) | (overrun & ~overrun_clr);
    end
endmodule

// File: tb/tb_dsm_cic_decimator.sv
// tb_dsm_cic_decimator: randomized bench against an impulse-response model of the CIC decimator
module tb_dsm_cic_decimator;
  localparam int R    = 64;
  localparam int NH   = 3 * (R - 1) + 1;
  localparam int RAND = 99;
  logic        clk = 0, rst_n = 0, fs_enb = 0, clr = 0, pcm_ready = 0, overrun_clr = 0;
  logic [3:0]  code_in = '0;
  logic [15:0] pcm_data;
  logic        pcm_valid, overrun;
  int          checks = 0, errors = 0, n_xfer = 0;
  int          h [NH];
  int          b2 [2*R-1];
  int          xs [$];
  logic [15:0] exp_q [$];
  logic [15:0] last_data;
  bit          mon_en = 0, rand_rdy = 0;

  dsm_cic_decimator dut (
    .clk(clk), .rst_n(rst_n), .fs_enb(fs_enb), .code_in(code_in), .clr(clr),
    .pcm_data(pcm_data), .pcm_valid(pcm_valid), .pcm_ready(pcm_ready),
    .overrun(overrun), .overrun_clr(overrun_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  // Output = full-rate convolution of the code history with the (sum of R ones)^3 kernel, scaled by 2^-6
  function automatic logic [15:0] model_out();
    longint s;
    int n;
    logic [21:0] a;
    s = 0;
    n = xs.size();
    for (int j = 0; j < NH && j < n; j++) s += longint'(h[j]) * longint'(xs[n-1-j]);
    a = s[21:0];
    return a[21:6];
  endfunction

  task automatic send(input int code, input bit idle);
    @(posedge clk); #1;
    fs_enb  = 1;
    code_in = code[3:0];
    xs.push_back(code);
    if (xs.size() % R == 0) exp_q.push_back(model_out());
    @(posedge clk); #1;
    fs_enb = 0;
    if (idle) repeat ($urandom_range(0, 1)) @(posedge clk);
  endtask

  function automatic int pick(input int code);
    return code == RAND ? int'($urandom_range(0, 15)) - 8 : code;
  endfunction

  task automatic run(input int code, input int nt);
    repeat (nt * R) send(pick(code), 1);
  endtask

  task automatic drain(input string tag);
    rand_rdy = 0;
    @(posedge clk); #2;
    pcm_ready = 1;
    for (int i = 0; i < 400 && exp_q.size() > 0; i++) @(posedge clk);
    chk(tag, exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic quiet(input string tag);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk(tag, pcm_valid, 0);
    end
  endtask

  always @(negedge clk)
    if (mon_en && pcm_valid && pcm_ready) begin
      if (exp_q.size() == 0) chk("unexpected_valid", 1, 0);
      else chk("pcm_data", $signed(pcm_data), $signed(exp_q.pop_front()));
      last_data = pcm_data;
      n_xfer++;
    end

  always @(posedge clk)
    if (rand_rdy) begin
      #1 pcm_ready = $urandom_range(0, 1) == 1;
    end

  initial begin
    int nx;
    for (int i = 0; i < R; i++) for (int j = 0; j < R; j++) b2[i+j]++;
    for (int i = 0; i < 2*R-1; i++) for (int k = 0; k < R; k++) h[i+k] += b2[i];
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", pcm_valid, 0);
    chk("rst_data", pcm_data, 0);
    chk("rst_overrun", overrun, 0);
    rst_n = 1;
    mon_en = 1;
    pcm_ready = 1;

    run(1, 6);
    drain("drain_plus1");
    chk("dc_plus1", $signed(last_data), 4096);
    chk("xfers_plus1", n_xfer, 6);
    chk("overrun_plus1", overrun, 0);

    repeat (R - 1) send(1, 1);
    send(1, 0);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("latency_edge%0d", k), pcm_valid, k == 4);
    end

    run(-8, 5);
    drain("drain_m8");
    chk("dc_minus8", $signed(last_data), -32768);
    run(7, 5);
    drain("drain_p7");
    chk("dc_plus7", $signed(last_data), 28672);

    rand_rdy = 1;
    run(RAND, 8);
    drain("drain_rand");
    chk("overrun_rand", overrun, 0);

    pcm_ready = 0;
    run(RAND, 2);
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("ovr_valid", pcm_valid, 1);
    chk("ovr_flag", overrun, 1);
    void'(exp_q.pop_front());
    chk("ovr_data", $signed(pcm_data), $signed(exp_q[0]));
    nx = n_xfer;
    @(posedge clk); #1 pcm_ready = 1;
    @(posedge clk); #1 pcm_ready = 0;
    @(negedge clk);
    chk("ovr_one_xfer", n_xfer, nx + 1);
    chk("ovr_after_valid", pcm_valid, 0);
    chk("ovr_sticky", overrun, 1);
    @(posedge clk); #1 overrun_clr = 1;
    @(posedge clk); #1 overrun_clr = 0;
    @(negedge clk);
    chk("ovr_cleared", overrun, 0);

    run(RAND, 1);
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("same_first_valid", pcm_valid, 1);
    repeat (R - 1) send(pick(RAND), 1);
    send(pick(RAND), 0);
    repeat (3) @(posedge clk);
    #1 pcm_ready = 1;
    @(posedge clk); #1 pcm_ready = 0;
    @(negedge clk);
    chk("same_valid", pcm_valid, 1);
    chk("same_overrun", overrun, 0);
    chk("same_data", $signed(pcm_data), exp_q.size() > 0 ? $signed(exp_q[0]) : 32'sd99999);
    drain("drain_same");

    repeat (R - 1) send(pick(RAND), 1);
    send(pick(RAND), 0);
    @(posedge clk); #1;
    clr = 1;
    fs_enb = 1;
    code_in = 4'd5;
    xs.delete();
    exp_q.delete();
    @(posedge clk); #1;
    clr = 0;
    fs_enb = 0;
    quiet("clr_no_valid");
    run(RAND, 3);
    drain("drain_clr");

    repeat (R - 1) send(pick(RAND), 1);
    send(pick(RAND), 0);
    @(posedge clk); #1;
    rst_n = 0;
    xs.delete();
    exp_q.delete();
    #3 rst_n = 1;
    quiet("rst_no_valid");
    run(RAND, 2);
    drain("drain_rst");
    chk("final_overrun", overrun, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
